// File: rtl/commit_pkg.sv
// Shared encodings for the commit scheduler.
//   itype_t  : ROB entry instruction class
//   state_t  : commit sequencer state
//   sttype_t : store size
package commit_pkg;

   typedef enum logic [2:0] {
      IT_ALU    = 3'd0,
      IT_LOAD   = 3'd1,
      IT_STORE  = 3'd2,
      IT_BRANCH = 3'd3,
      IT_JUMP   = 3'd4
   } itype_t;

   typedef enum logic [1:0] {
      S_COMMIT     = 2'd0,
      S_STORE_WAIT = 2'd1,
      S_FLUSH      = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ST_BYTE = 2'd0,
      ST_HALF = 2'd1,
      ST_WORD = 2'd2
   } sttype_t;

   // ALU and LOAD entries are the only ones that may pair up in one cycle.
   function automatic logic is_alu_ld(input logic [2:0] t);
      return (t == IT_ALU) || (t == IT_LOAD);
   endfunction

endpackage

// File: rtl/commit_slot_eligibility.sv
// Combinational slot qualification for the two oldest ROB entries.
// Inputs : state, st_ack, head_valid/done/mispred (2b), head_type (2x3),
//          head_rd (2x5)
// Outputs: c0/c1 slot commits, st0 store start, fl0 mispredict flush,
//          wb0/wb1 register write enables, pop (entries retired this cycle)
module commit_slot_eligibility
   import commit_pkg::*;
(
   input  state_t     state,
   input  logic       st_ack,
   input  logic [1:0] head_valid,
   input  logic [1:0] head_done,
   input  logic [1:0] head_mispred,
   input  logic [5:0] head_type,
   input  logic [9:0] head_rd,
   output logic       c0,
   output logic       c1,
   output logic       st0,
   output logic       fl0,
   output logic       wb0,
   output logic       wb1,
   output logic [1:0] pop
);

   logic [2:0] t0, t1;
   logic [1:0] rdy;
   logic       in_commit, ctl0;

   assign t0        = head_type[2:0];
   assign t1        = head_type[5:3];
   assign rdy       = head_valid & head_done;
   assign in_commit = (state == S_COMMIT);
   assign ctl0      = (t0 == IT_BRANCH) || (t0 == IT_JUMP);

   // Stores go through the handshake instead of retiring directly.
   assign st0 = in_commit && rdy[0] && (t0 == IT_STORE);
   assign c0  = in_commit && rdy[0] && (t0 != IT_STORE);
   assign fl0 = c0 && ctl0 && head_mispred[0];
   assign c1  = c0 && rdy[1] && is_alu_ld(t0) && is_alu_ld(t1) && !(|head_mispred);

   // JUMP writes its link register; BRANCH/STORE never write.
   assign wb0 = c0 && (is_alu_ld(t0) || (t0 == IT_JUMP)) && (head_rd[4:0] != 5'd0);
   assign wb1 = c1 && (head_rd[9:5] != 5'd0);

   always_comb begin
      pop = 2'd0;
      case (state)
         S_COMMIT:     pop = c1 ? 2'd2 : (c0 ? 2'd1 : 2'd0);
         S_STORE_WAIT: pop = st_ack ? 2'd1 : 2'd0;
         default:      pop = 2'd0;
      endcase
   end

endmodule

// File: rtl/commit_scheduler.sv
// Retires up to two ROB head entries per cycle, serialises stores through a
// req/ack port, and sequences flush/redirect on a control-flow mispredict.
// Ports: head_* ROB head view (slot 0 in low bits), rob_pop combinational pop
// count, WB_* / store_* / branch_* / jump_* registered commit outputs,
// flush_en/redirect_pc, st_req/st_ack store handshake, store_err sticky
// timeout flag, rob_full (status only).
// Optional: COMMIT_SCHED_PERF_EN adds perf_cycles/perf_retired/perf_stall.
module commit_scheduler
   import commit_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int FLUSH_CYCLES  = 3,
   parameter int STORE_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        head_valid,
   input  logic [1:0]        head_done,
   input  logic [5:0]        head_type,
   input  logic [9:0]        head_rd,
   input  logic [2*XLEN-1:0] head_data,
   input  logic [2*XLEN-1:0] head_pc,
   input  logic [1:0]        head_mispred,
   input  logic [2*XLEN-1:0] head_target,
   input  logic [XLEN-1:0]   head_st_addr,
   input  logic [1:0]        head_st_type,
   output logic [1:0]        rob_pop,
   output logic              WB_en1,
   output logic              WB_en2,
   output logic [4:0]        WB_target1,
   output logic [4:0]        WB_target2,
   output logic [XLEN-1:0]   WB_data1,
   output logic [XLEN-1:0]   WB_data2,
   output logic              store_en,
   output logic [XLEN-1:0]   store_addr,
   output logic [XLEN-1:0]   store_value,
   output logic [1:0]        store_type,
   output logic              branch_en,
   output logic              jump_en,
   output logic [XLEN-1:0]   branch_target_pc,
   output logic [XLEN-1:0]   jump_target_pc,
   output logic [XLEN-1:0]   ins_pc,
   output logic              flush_en,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              st_req,
   input  logic              st_ack,
   output logic              store_err,
   input  logic              rob_full
`ifdef COMMIT_SCHED_PERF_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_retired,
   output logic [31:0]       perf_stall
`endif
);

   // One counter serves both the store timeout and the flush countdown.
   localparam int CMAX = (STORE_TIMEOUT > FLUSH_CYCLES) ? STORE_TIMEOUT : FLUSH_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(STORE_TIMEOUT - 1);
   localparam logic [CW-1:0] TMO_SAT  = CW'(STORE_TIMEOUT);
   localparam logic [CW-1:0] FL_INIT  = CW'(FLUSH_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          c0, c1, st0, fl0, wb0, wb1;
   logic [2:0]    t0;
   logic          unused_ok;

   assign t0        = head_type[2:0];
   assign unused_ok = ^{rob_full, head_pc[2*XLEN-1:XLEN], head_target[2*XLEN-1:XLEN]};

   commit_slot_eligibility u_elig (
      .state        (state),
      .st_ack       (st_ack),
      .head_valid   (head_valid),
      .head_done    (head_done),
      .head_mispred (head_mispred),
      .head_type    (head_type),
      .head_rd      (head_rd),
      .c0           (c0),
      .c1           (c1),
      .st0          (st0),
      .fl0          (fl0),
      .wb0          (wb0),
      .wb1          (wb1),
      .pop          (rob_pop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_COMMIT;
         cnt              <= '0;
         WB_en1           <= 1'b0;
         WB_en2           <= 1'b0;
         WB_target1       <= '0;
         WB_target2       <= '0;
         WB_data1         <= '0;
         WB_data2         <= '0;
         store_en         <= 1'b0;
         store_addr       <= '0;
         store_value      <= '0;
         store_type       <= '0;
         branch_en        <= 1'b0;
         jump_en          <= 1'b0;
         branch_target_pc <= '0;
         jump_target_pc   <= '0;
         ins_pc           <= '0;
         flush_en         <= 1'b0;
         redirect_pc      <= '0;
         st_req           <= 1'b0;
         store_err        <= 1'b0;
      end else begin
         WB_en1    <= 1'b0;
         WB_en2    <= 1'b0;
         store_en  <= 1'b0;
         branch_en <= 1'b0;
         jump_en   <= 1'b0;
         flush_en  <= 1'b0;
         case (state)
            S_COMMIT: begin
               if (st0) begin
                  st_req      <= 1'b1;
                  store_addr  <= head_st_addr;
                  store_value <= head_data[XLEN-1:0];
                  store_type  <= head_st_type;
                  cnt         <= '0;
                  state       <= S_STORE_WAIT;
               end
               if (c0) begin
                  ins_pc     <= head_pc[XLEN-1:0];
                  WB_en1     <= wb0;
                  WB_target1 <= head_rd[4:0];
                  WB_data1   <= head_data[XLEN-1:0];
                  if (t0 == IT_BRANCH) begin
                     branch_en        <= 1'b1;
                     branch_target_pc <= head_target[XLEN-1:0];
                  end
                  if (t0 == IT_JUMP) begin
                     jump_en        <= 1'b1;
                     jump_target_pc <= head_target[XLEN-1:0];
                  end
               end
               if (fl0) begin
                  flush_en    <= 1'b1;
                  redirect_pc <= head_target[XLEN-1:0];
                  cnt         <= FL_INIT;
                  state       <= S_FLUSH;
               end
               if (c1) begin
                  WB_en2     <= wb1;
                  WB_target2 <= head_rd[9:5];
                  WB_data2   <= head_data[2*XLEN-1:XLEN];
               end
            end
            S_STORE_WAIT: begin
               if (st_ack) begin
                  st_req   <= 1'b0;
                  store_en <= 1'b1;
                  ins_pc   <= head_pc[XLEN-1:0];
                  state    <= S_COMMIT;
               end else if (cnt != TMO_SAT) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == TMO_LAST) store_err <= 1'b1;
               end
            end
            S_FLUSH: begin
               if (cnt == '0) state <= S_COMMIT;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= S_COMMIT;
         endcase
      end
   end

`ifdef COMMIT_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles  <= '0;
         perf_retired <= '0;
         perf_stall   <= '0;
      end else begin
         perf_cycles  <= perf_cycles + 32'd1;
         perf_retired <= perf_retired + 32'(rob_pop);
         if ((state != S_COMMIT) || ((rob_pop == 2'd0) && head_valid[0]))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
